// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable sequence-detector controller.
package seq_det_pkg;

  // Controller states; the encoding is fixed so the host can decode a state dump.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHunt = 2'd1,
    StDone = 2'd2,
    StTmo  = 2'd3
  } state_e;

  // Power-on configuration reproduces the fixed overlapping "1111" detector.
  localparam logic        DefPatBit = 1'b1;  // replicated across the whole pattern register
  localparam int unsigned DefLen    = 4;
  localparam logic        DefOvl    = 1'b1;

  // Width needed to hold a length in the range 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// Serial shift register, fill counter and masked pattern compare.
// hit is asserted for the cycle after the completing bit has been shifted in.
module seq_shift_match
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,       // clear history when (re)arming
  input  logic               shift_en,  // qualified bit to shift in this cycle
  input  logic               in_bit,
  input  logic               ovl_clr,   // non-overlapping mode: restart fill after a hit
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pat,
  output logic               hit
);

  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_base;
  logic               shifted_q, shifted_d;
  logic [MAX_LEN-1:0] mask;

  // Next-state for shift register, fill count and the "just shifted" marker.
  always_comb begin
    shift_d   = shift_q;
    fill_base = ovl_clr ? '0 : fill_q;
    fill_d    = fill_base;
    shifted_d = shift_en;
    if (clr) begin
      shift_d   = '0;
      fill_d    = '0;
      shifted_d = 1'b0;
    end else if (shift_en) begin
      shift_d = (shift_q << 1) | MAX_LEN'(in_bit);
      // A bit arriving in the same cycle as an overlap clear is the first fresh bit.
      if (fill_base < len) begin
        fill_d = fill_base + LEN_W'(1);
      end
    end
  end

  // Low-len-bits mask for the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  // Compare the post-shift value; only a cycle that follows a shift can hit,
  // so an idle in_vld gap never repeats a match.
  always_comb begin
    hit = shifted_q && (fill_q == len) && (((shift_q ^ pat) & mask) == '0);
  end

  // History registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      fill_q    <= '0;
      shifted_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      fill_q    <= fill_d;
      shifted_q <= shifted_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable sequence-detector controller: configuration registers, arm/disarm
// FSM, match counter, timeout timer and status flags around seq_shift_match.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 8,
  parameter  int unsigned CNT_W   = 8,
  parameter  int unsigned TMO_W   = 16,
  localparam int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic [CNT_W-1:0]   cfg_tgt,
  input  logic [TMO_W-1:0]   cfg_tmo,
  input  logic               start,
  input  logic               abort,
  input  logic               in,
  input  logic               in_vld,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  state_e state_q, state_d;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TMO_W-1:0] tmr_q, tmr_d, tmr_inc;
  logic             match_q, match_d;

  logic hunting, arm, hit, hunt_hit, tgt_reached, tmo_expired;

  // Shared qualifiers; abort suppresses everything else in the cycle.
  always_comb begin
    hunting     = (state_q == StHunt);
    arm         = start && !abort && !hunting;
    hunt_hit    = hunting && !abort && hit;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    tmr_inc     = tmr_q + TMO_W'(1);
    tgt_reached = (tgt_q != '0) && (cnt_inc == tgt_q);
    tmo_expired = (tmo_q != '0) && (tmr_inc == tmo_q);
  end

  seq_shift_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shift_match (
    .clk      (clk),
    .rst      (rst),
    .clr      (arm),
    .shift_en (hunting && !abort && in_vld),
    .in_bit   (in),
    .ovl_clr  (hunt_hit && !ovl_q),
    .len      (len_q),
    .pat      (pat_q),
    .hit      (hit)
  );

  // Configuration write, blocked while hunting; length clamped to 1..MAX_LEN.
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    tgt_d = tgt_q;
    tmo_d = tmo_q;
    if (cfg_we && !hunting) begin
      pat_d = cfg_pat;
      ovl_d = cfg_ovl;
      tgt_d = cfg_tgt;
      tmo_d = cfg_tmo;
      if (cfg_len == '0) begin
        len_d = LEN_W'(1);
      end else if (cfg_len > LEN_W'(MAX_LEN)) begin
        len_d = LEN_W'(MAX_LEN);
      end else begin
        len_d = cfg_len;
      end
    end
  end

  // Configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= {MAX_LEN{DefPatBit}};
      len_q <= LEN_W'(DefLen);
      ovl_q <= DefOvl;
      tgt_q <= '0;
      tmo_q <= '0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      tgt_q <= tgt_d;
      tmo_q <= tmo_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: abort first, then hit (target), then timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StTmo: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StHunt;
        end
      end
      StHunt: begin
        if (abort) begin
          state_d = StIdle;
        end else if (hit) begin
          if (tgt_reached) begin
            state_d = StDone;
          end
        end else if (tmo_expired) begin
          state_d = StTmo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; done/timeout are held by the state itself until start or abort.
  always_comb begin
    busy    = (state_q == StHunt);
    done    = (state_q == StDone);
    timeout = (state_q == StTmo);
  end

  // Match pulse, saturating counter and no-hit timer.
  always_comb begin
    match_d = 1'b0;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    if (arm) begin
      cnt_d = '0;
      tmr_d = '0;
    end else if (hunting && !abort) begin
      tmr_d = tmr_inc;
      if (hunt_hit) begin
        match_d = 1'b1;
        cnt_d   = cnt_inc;
        tmr_d   = '0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      match_q <= match_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_ovl = 1'b0;
  logic [7:0] cfg_tgt = '0;
  logic [15:0] cfg_tmo = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_vld = 1'b0;
  logic       match;
  logic [7:0] match_cnt;
  logic       busy, done, timeout;

  int n_cmp = 0;
  int n_err = 0;

  seq_det_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .cfg_ovl   (cfg_ovl),
    .cfg_tgt   (cfg_tgt),
    .cfg_tmo   (cfg_tmo),
    .start     (start),
    .abort     (abort),
    .in        (in_bit),
    .in_vld    (in_vld),
    .match     (match),
    .match_cnt (match_cnt),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; returns 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic [7:0] tgt, input logic [15:0] tmo);
    cfg_pat = pat; cfg_len = len; cfg_ovl = ovl; cfg_tgt = tgt; cfg_tmo = tmo;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // Sends n valid bits MSB first; mv[k] is match seen one edge after bit k.
  task automatic run_stream(input logic [31:0] bits, input int n, output logic [31:0] mv);
    mv = '0;
    for (int i = 0; i < n; i++) begin
      in_bit = bits[n-1-i];
      in_vld = 1'b1;
      step();
      if (i > 0) mv[i-1] = match;
    end
    in_vld = 1'b0;
    in_bit = 1'b0;
    step();
    mv[n-1] = match;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mv;
    logic [31:0] tv;
    logic [3:0]  gbits;

    // Reset state
    #12 rst = 1'b0;
    step();
    check("rst_match", match, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tmo", timeout, 0);

    // 1: defaults, seven ones, overlapping
    do_start();
    check("t1_busy", busy, 1);
    run_stream(32'h7f, 7, mv);
    check("t1_matches", mv, 32'h78);
    check("t1_cnt", match_cnt, 4);
    check("t1_done", done, 0);
    do_abort();
    check("t1_abort_busy", busy, 0);
    check("t1_abort_cnt", match_cnt, 4);

    // 2: non-overlapping 1111, nine ones
    do_cfg(8'h0f, 4'd4, 1'b0, 8'd0, 16'd0);
    do_start();
    check("t2_cnt_clr", match_cnt, 0);
    run_stream(32'h1ff, 9, mv);
    check("t2_matches", mv, 32'h88);
    check("t2_cnt", match_cnt, 2);
    do_abort();

    // 3: pattern 1011, target 2
    do_cfg(8'h0b, 4'd4, 1'b1, 8'd2, 16'd0);
    do_start();
    run_stream(32'h5b, 7, mv);
    check("t3_matches", mv, 32'h48);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_cnt", match_cnt, 2);
    run_stream(32'hb, 4, mv);
    check("t3_ignored", mv, 0);
    check("t3_cnt_hold", match_cnt, 2);
    check("t3_done_hold", done, 1);

    // 4: timeout of 10 cycles, then reconfigure + rearm in TMO
    do_cfg(8'h0b, 4'd4, 1'b1, 8'd0, 16'd10);
    do_start();
    check("t4_cnt_clr", match_cnt, 0);
    check("t4_done_clr", done, 0);
    tv = '0;
    in_bit = 1'b0;
    in_vld = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      tv[k] = timeout;
    end
    in_vld = 1'b0;
    check("t4_tmo_time", tv, 32'h200);
    check("t4_busy", busy, 0);
    step();
    check("t4_tmo_hold", timeout, 1);
    cfg_pat = 8'h03; cfg_len = 4'd2; cfg_ovl = 1'b1; cfg_tgt = 8'd0; cfg_tmo = 16'd0;
    cfg_we = 1'b1;
    start = 1'b1;
    step();
    cfg_we = 1'b0;
    start = 1'b0;
    check("t4_rearm_tmo", timeout, 0);
    check("t4_rearm_busy", busy, 1);
    run_stream(32'h3, 2, mv);
    check("t4_len2_match", mv, 32'h2);

    // 5: abort on the completing bit, then rst mid-HUNT
    do_abort();
    do_cfg(8'h0f, 4'd4, 1'b1, 8'd0, 16'd0);
    do_start();
    run_stream(32'hf, 4, mv);
    check("t5_first", mv, 32'h8);
    check("t5_cnt1", match_cnt, 1);
    in_bit = 1'b1;
    in_vld = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    in_vld = 1'b0;
    step();
    check("t5_abort_match", match, 0);
    check("t5_abort_cnt", match_cnt, 1);
    check("t5_abort_busy", busy, 0);

    do_cfg(8'h55, 4'd8, 1'b0, 8'd3, 16'd5);
    do_start();
    run_stream(32'h1, 2, mv);
    check("t5_pre_rst_busy", busy, 1);
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_cnt", match_cnt, 0);
    check("t5_rst_tmo", timeout, 0);
    step();
    do_start();
    run_stream(32'h1f, 5, mv);
    check("t5_rst_defaults", mv, 32'h18);
    check("t5_rst_cnt2", match_cnt, 2);
    repeat (6) step();
    check("t5_rst_no_tmo", timeout, 0);
    check("t5_rst_no_done", done, 0);

    // 6: gapped 1011 stream; cfg_we during HUNT must be ignored
    do_abort();
    do_cfg(8'h0b, 4'd4, 1'b1, 8'd0, 16'd0);
    do_start();
    do_cfg(8'h02, 4'd2, 1'b1, 8'd0, 16'd0);
    gbits = 4'b1011;
    tv = '0;
    for (int k = 0; k < 4; k++) begin
      in_bit = gbits[3-k];
      in_vld = 1'b1;
      step();
      tv[k*4] = match;
      in_vld = 1'b0;
      in_bit = ~gbits[3-k];
      for (int g = 1; g < 4; g++) begin
        step();
        tv[k*4+g] = match;
      end
    end
    step();
    tv[16] = match;
    check("t6_gapped", tv, 32'h2000);
    check("t6_cnt", match_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
